// File: rtl/bkm_result_buffer_pkg.sv
// Shared definitions for the BKM result buffer: flag layout and default sizing.
package bkm_result_buffer_pkg;

    localparam int FSIZE = 5;

    localparam int FLAG_INVALID   = 0;
    localparam int FLAG_DIVZERO   = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 3;
    localparam int FLAG_INEXACT   = 4;

    localparam int BKM_RB_DEPTH = 2;
    localparam int BKM_RB_W     = 64;

    function automatic int rb_entry_width(input int w);
        return 2 * w + FSIZE;
    endfunction

endpackage

// File: rtl/bkm_fifo_mem.sv
// Result storage: DEPTH x DW register array, one write port, combinational read port.
module bkm_fifo_mem #(
    parameter int DEPTH = 2,
    parameter int AW    = 1,
    parameter int DW    = 133
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    // No reset: contents are only observable once the pointers say they are valid.
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bkm_result_buffer.sv
// Small FIFO between the BKM iteration stage and the FPU output port, with
// valid/ready presentation, sticky drop flag and occupancy count.
module bkm_result_buffer
    import bkm_result_buffer_pkg::*;
#(
    parameter int W     = BKM_RB_W,
    parameter int DEPTH = BKM_RB_DEPTH,
    parameter int LOG2D = 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             srst,
    input  logic             enable,
    input  logic             done_in,
    input  logic [W-1:0]     X_in,
    input  logic [W-1:0]     Y_in,
    input  logic [FSIZE-1:0] flags_in,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     X_out,
    output logic [W-1:0]     Y_out,
    output logic [FSIZE-1:0] flags_out,
    output logic [LOG2D:0]   count,
    output logic             overflow
);

    localparam int             EW        = 2 * W + FSIZE;
    localparam logic [LOG2D:0] FULL_CNT  = (LOG2D + 1)'(DEPTH);
    localparam logic [LOG2D:0] CNT_ONE   = (LOG2D + 1)'(1);
    localparam logic [LOG2D-1:0] PTR_ONE = LOG2D'(1);

    logic [LOG2D-1:0] wr_ptr_reg, wr_ptr_next;
    logic [LOG2D-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LOG2D:0]   count_reg, count_next;
    logic             overflow_reg, overflow_next;

    logic             is_full, is_empty;
    logic             push, pop, drop;
    logic [EW-1:0]    wr_data, rd_data;

    assign is_full  = (count_reg == FULL_CNT);
    assign is_empty = (count_reg == '0);

    // A full buffer can still accept a result if the head leaves in the same cycle.
    assign pop  = enable & ~is_empty & out_ready;
    assign push = enable & done_in & (~is_full | pop);
    assign drop = enable & done_in & is_full & ~pop;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg | drop;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (srst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (enable) begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    assign wr_data = {X_in, Y_in, flags_in};

    bkm_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (LOG2D),
        .DW    (EW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push & ~srst),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

    // Outputs depend only on registered state, never on done_in or out_ready.
    assign out_valid = ~is_empty;
    assign in_ready  = ~is_full;
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign X_out     = is_empty ? '0 : rd_data[EW-1 -: W];
    assign Y_out     = is_empty ? '0 : rd_data[FSIZE +: W];
    assign flags_out = is_empty ? '0 : rd_data[FSIZE-1:0];

endmodule
